// File: rtl/piezo_tone_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : piezo_tone_decoder
// Brief    : Recovers the note code and duration from a piezo square wave.
// Revision : 1.0
// ============================================================================

module piezo_tone_decoder #(
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 8,
  parameter int QUARTER  = 250000,
  parameter int MAX_HALF = 2047
) (
  input  logic       RESETN,
  input  logic       CLK_1MHZ,
  input  logic       PIEZO_IN,
  output logic [3:0] NOTE,
  output logic       NOTE_VALID,
  output logic       NOTE_DONE,
  output logic [3:0] LAST_NOTE,
  output logic [7:0] DUR
);

  localparam int c_HPW = $clog2(MAX_HALF + 1);
  localparam int c_TW  = $clog2(QUARTER);
  localparam int c_MW  = $clog2(LOCK_CNT + 1);

  localparam logic [c_HPW-1:0] c_HP_MAX     = c_HPW'(MAX_HALF);
  localparam logic [c_TW-1:0]  c_TICK_LAST  = c_TW'(QUARTER - 1);
  localparam logic [c_TW-1:0]  c_TICK_HALF  = c_TW'(QUARTER / 2);
  localparam logic [c_MW-1:0]  c_MATCH_LOCK = c_MW'(LOCK_CNT);

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  function automatic int note_half(input int code);
    case (code)
      1:       note_half = 675;
      2:       note_half = 758;
      3:       note_half = 851;
      4:       note_half = 902;
      5:       note_half = 955;
      6:       note_half = 1012;
      7:       note_half = 1136;
      8:       note_half = 1204;
      9:       note_half = 1275;
      10:      note_half = 1351;
      11:      note_half = 1431;
      12:      note_half = 1516;
      13:      note_half = 1607;
      default: note_half = 0;
    endcase
  endfunction

  // Table entries are half-period minus one, so the edge-to-edge count is F+1.
  function automatic logic [3:0] classify(input logic [c_HPW:0] h);
    int          hv;
    int          ref_h;
    logic [3:0]  code;
    hv   = int'(h);
    code = 4'd0;
    for (int i = 1; i <= 13; i++) begin
      ref_h = note_half(i) + 1;
      if (hv >= ref_h - TOL && hv <= ref_h + TOL) code = 4'(i);
    end
    return code;
  endfunction

  logic [1:0]       r_sync;
  logic             r_prev;
  logic [c_HPW-1:0] r_hp;
  state_t           r_state;
  logic [3:0]       r_cand;
  logic [c_MW-1:0]  r_match;
  logic [c_TW-1:0]  r_tick;
  logic [7:0]       r_qcnt;
  logic [3:0]       r_note;
  logic             r_valid;
  logic             r_done;
  logic [3:0]       r_last;
  logic [7:0]       r_dur;

  logic             w_edge;
  logic [c_HPW:0]   w_h;
  logic [3:0]       w_code;
  logic             w_timeout;
  logic [c_MW-1:0]  w_match_inc;
  logic [8:0]       w_dur_sum;
  logic [7:0]       w_dur;

  assign w_edge      = r_sync[1] ^ r_prev;
  assign w_h         = {1'b0, r_hp} + {{c_HPW{1'b0}}, 1'b1};
  assign w_code      = classify(w_h);
  assign w_timeout   = !w_edge && (r_hp == c_HP_MAX);
  assign w_match_inc = r_match + c_MW'(1);
  assign w_dur_sum   = {1'b0, r_qcnt} + {8'd0, (r_tick >= c_TICK_HALF)};
  assign w_dur       = w_dur_sum[8] ? 8'hFF : w_dur_sum[7:0];

  always_ff @(posedge CLK_1MHZ or negedge RESETN) begin
    if (!RESETN) begin
      r_sync  <= 2'b00;
      r_prev  <= 1'b0;
      r_hp    <= c_HP_MAX;
      r_state <= SILENT;
      r_cand  <= 4'd0;
      r_match <= '0;
      r_tick  <= '0;
      r_qcnt  <= 8'd0;
      r_note  <= 4'd0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_last  <= 4'd0;
      r_dur   <= 8'd0;
    end else begin
      r_sync <= {r_sync[0], PIEZO_IN};
      r_prev <= r_sync[1];
      r_done <= 1'b0;

      if (w_edge)
        r_hp <= '0;
      else if (r_hp != c_HP_MAX)
        r_hp <= r_hp + c_HPW'(1);

      // Elapsed time runs from the first candidate edge until the note ends.
      if (r_state != SILENT) begin
        if (r_tick == c_TICK_LAST) begin
          r_tick <= '0;
          if (r_qcnt != 8'hFF) r_qcnt <= r_qcnt + 8'd1;
        end else begin
          r_tick <= r_tick + c_TW'(1);
        end
      end

      case (r_state)
        SILENT: begin
          if (w_edge && w_code != 4'd0) begin
            r_cand  <= w_code;
            r_match <= c_MW'(1);
            r_tick  <= '0;
            r_qcnt  <= 8'd0;
            r_state <= ACQUIRE;
          end
        end
        ACQUIRE: begin
          if (w_edge) begin
            if (w_code == 4'd0) begin
              r_state <= SILENT;
            end else if (w_code == r_cand) begin
              r_match <= w_match_inc;
              if (w_match_inc == c_MATCH_LOCK) begin
                r_note  <= r_cand;
                r_valid <= 1'b1;
                r_state <= LOCKED;
              end
            end else begin
              r_cand  <= w_code;
              r_match <= c_MW'(1);
              r_tick  <= '0;
              r_qcnt  <= 8'd0;
            end
          end else if (w_timeout) begin
            r_state <= SILENT;
          end
        end
        LOCKED: begin
          if ((w_edge && w_code != r_note) || w_timeout) begin
            r_done  <= 1'b1;
            r_last  <= r_note;
            r_dur   <= w_dur;
            r_note  <= 4'd0;
            r_valid <= 1'b0;
            if (w_edge && w_code != 4'd0) begin
              r_cand  <= w_code;
              r_match <= c_MW'(1);
              r_tick  <= '0;
              r_qcnt  <= 8'd0;
              r_state <= ACQUIRE;
            end else begin
              r_state <= SILENT;
            end
          end
        end
        default: r_state <= SILENT;
      endcase
    end
  end

  assign NOTE       = r_note;
  assign NOTE_VALID = r_valid;
  assign NOTE_DONE  = r_done;
  assign LAST_NOTE  = r_last;
  assign DUR        = r_dur;

endmodule

`default_nettype wire

// File: tb/tb_piezo_tone_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_piezo_tone_decoder
// Brief    : Randomized scoreboard bench for piezo_tone_decoder.
// Revision : 1.0
// ============================================================================

module tb_piezo_tone_decoder;

  localparam int LOCK = 4;
  localparam int TOL  = 8;
  localparam int Q    = 1000;
  localparam int SAT  = 2048;

  logic       CLK_1MHZ = 1'b0;
  logic       RESETN   = 1'b0;
  logic       PIEZO_IN = 1'b0;
  logic [3:0] NOTE;
  logic       NOTE_VALID;
  logic       NOTE_DONE;
  logic [3:0] LAST_NOTE;
  logic [7:0] DUR;

  piezo_tone_decoder #(
    .LOCK_CNT(LOCK), .TOL(TOL), .QUARTER(Q), .MAX_HALF(2047)
  ) dut (
    .RESETN(RESETN), .CLK_1MHZ(CLK_1MHZ), .PIEZO_IN(PIEZO_IN),
    .NOTE(NOTE), .NOTE_VALID(NOTE_VALID), .NOTE_DONE(NOTE_DONE),
    .LAST_NOTE(LAST_NOTE), .DUR(DUR)
  );

  always #5 CLK_1MHZ = ~CLK_1MHZ;

  int cyc = 0;
  always @(posedge CLK_1MHZ) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int clk;
    int code;
    int dur;
  } ev_t;

  ev_t lock_q[$];
  ev_t done_q[$];

  int half_tbl[13] = '{675, 758, 851, 902, 955, 1012, 1136, 1204, 1275, 1351, 1431, 1516, 1607};

  // Reference model works on edge timestamps: 0 silent, 1 acquiring, 2 locked.
  int m_state = 0;
  int m_cand  = 0;
  int m_match = 0;
  int m_note  = 0;
  int m_start = 0;
  int m_prev  = 0;
  bit m_sat   = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int classify_m(input int g);
    for (int k = 0; k < 13; k++) begin
      int d;
      d = g - (half_tbl[k] + 1);
      if (d <= TOL && d >= -TOL) return k + 1;
    end
    return 0;
  endfunction

  function automatic void end_note(input int t);
    ev_t e;
    int  n, q;
    n = t - m_start - 1;
    q = n / Q;
    if ((n % Q) >= Q / 2) q++;
    if (q > 255) q = 255;
    e.clk  = t;
    e.code = m_note;
    e.dur  = q;
    done_q.push_back(e);
    m_note = 0;
  endfunction

  // Apply a silence timeout if one falls at or before the given clock.
  function automatic void advance(input int limit);
    if (!m_sat && m_prev + SAT <= limit) begin
      m_sat = 1'b1;
      if (m_state == 2) end_note(m_prev + SAT);
      m_state = 0;
    end
  endfunction

  function automatic void model_edge(input int e_clk);
    int  g, c;
    ev_t e;
    advance(e_clk - 1);
    g      = m_sat ? SAT : e_clk - m_prev;
    c      = classify_m(g);
    m_prev = e_clk;
    m_sat  = 1'b0;
    case (m_state)
      0: if (c != 0) begin
        m_cand = c; m_match = 1; m_start = e_clk; m_state = 1;
      end
      1: if (c == 0) begin
        m_state = 0;
      end else if (c == m_cand) begin
        m_match++;
        if (m_match == LOCK) begin
          m_note = c; m_state = 2;
          e.clk = e_clk; e.code = c; e.dur = 0;
          lock_q.push_back(e);
        end
      end else begin
        m_cand = c; m_match = 1; m_start = e_clk;
      end
      default: if (c != m_note) begin
        end_note(e_clk);
        if (c != 0) begin
          m_cand = c; m_match = 1; m_start = e_clk; m_state = 1;
        end else begin
          m_state = 0;
        end
      end
    endcase
  endfunction

  // An input change made at this negedge is classified on the third following clock.
  task automatic step(input logic v);
    @(negedge CLK_1MHZ);
    advance(cyc + 1);
    if (v != PIEZO_IN) begin
      PIEZO_IN = v;
      model_edge(cyc + 3);
    end
  endtask

  task automatic tone(input int h, input int n);
    repeat (n) begin
      step(!PIEZO_IN);
      repeat (h - 1) step(PIEZO_IN);
    end
  endtask

  task automatic silence(input int n);
    repeat (n) step(PIEZO_IN);
  endtask

  task automatic rest(input int n);
    repeat (n) step(!PIEZO_IN);
  endtask

  task automatic do_reset();
    silence(10);
    @(negedge CLK_1MHZ);
    #1 RESETN = 1'b0;
    #1;
    chk("rst_note", NOTE, 0);
    chk("rst_valid", NOTE_VALID, 0);
    chk("rst_last", LAST_NOTE, 0);
    chk("rst_dur", DUR, 0);
    repeat (5) begin
      @(negedge CLK_1MHZ);
      chk("rst_done", NOTE_DONE, 0);
    end
    PIEZO_IN = 1'b0;
    m_state = 0; m_note = 0; m_sat = 1'b1;
    @(negedge CLK_1MHZ);
    RESETN = 1'b1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a lock or a note end.
  initial begin
    logic pv;
    ev_t  e;
    pv = 1'b0;
    forever begin
      @(negedge CLK_1MHZ);
      if (RESETN) begin
        if (NOTE_VALID && !pv) begin
          if (lock_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL lock_unexpected: got note %0d required no lock (cycle %0d)", NOTE, cyc);
          end else begin
            e = lock_q.pop_front();
            chk("lock_cycle", cyc, e.clk);
            chk("lock_note", NOTE, e.code);
          end
        end
        if (NOTE_DONE) begin
          if (done_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL done_unexpected: got last %0d dur %0d required no note end (cycle %0d)",
                     LAST_NOTE, DUR, cyc);
          end else begin
            e = done_q.pop_front();
            chk("done_cycle", cyc, e.clk);
            chk("done_last", LAST_NOTE, e.code);
            chk("done_dur", DUR, e.dur);
            chk("done_note_clr", NOTE, 0);
            chk("done_valid_clr", NOTE_VALID, 0);
          end
        end
      end
      pv = NOTE_VALID;
    end
  end

  initial begin
    int sel, k, h, n;
    repeat (3) @(negedge CLK_1MHZ);
    chk("init_note", NOTE, 0);
    chk("init_valid", NOTE_VALID, 0);
    chk("init_done", NOTE_DONE, 0);
    chk("init_last", LAST_NOTE, 0);
    chk("init_dur", DUR, 0);
    RESETN = 1'b1;

    tone(956, 5);  silence(2200);
    tone(1013, 5); tone(1137, 5); silence(2200);
    tone(1021, 5); silence(2200);
    tone(1022, 5); silence(2200);
    tone(956, 5);  rest(8); silence(2200);
    tone(956, 3);  tone(852, 5); silence(2200);
    tone(956, 5);  do_reset();
    tone(758, 5);  silence(2200);

    while (cyc < 68000) begin
      sel = $urandom_range(0, 9);
      if (sel <= 5) begin
        k = $urandom_range(0, 12);
        h = half_tbl[k] + 1 + $urandom_range(0, 20) - 10;
        tone(h, $urandom_range(2, 6));
      end else if (sel == 6) begin
        silence($urandom_range(2049, 2400));
      end else if (sel == 7) begin
        rest($urandom_range(2, 10));
      end else if (sel == 8) begin
        h = $urandom_range(2, 2000);
        n = $urandom_range(1, 3);
        tone(h, n);
      end else begin
        do_reset();
      end
    end

    silence(2200);
    silence(5);
    chk("locks_pending", lock_q.size(), 0);
    chk("dones_pending", done_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
